cacheline_arbiter: RTL and testbench
====================================

Name: cacheline_arbiter

Overview:
- Shares the single physical-memory cacheline port between the instruction cache and the data cache of the pipelined CPU.
- Sits between the two L1 caches and the cacheline adaptor.
- Sequences one full cacheline transaction at a time through a small FSM.
- Resolves simultaneous misses by round-robin, so a stream of data misses cannot starve instruction fetch, and vice versa.

Parameters:
- ADDR_W, 32, address width in bits.
- LINE_W, 256, cacheline width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- icache_pmem_read  in  1  I-cache line-fill request.
- icache_pmem_address  in  ADDR_W  I-cache line address.
- icache_pmem_rdata  out  LINE_W  line returned to I-cache.
- icache_pmem_resp  out  1  I-cache transaction done, 1-cycle pulse.
- dcache_pmem_read  in  1  D-cache line-fill request.
- dcache_pmem_write  in  1  D-cache write-back request.
- dcache_pmem_address  in  ADDR_W  D-cache line address.
- dcache_pmem_wdata  in  LINE_W  write-back line.
- dcache_pmem_rdata  out  LINE_W  line returned to D-cache.
- dcache_pmem_resp  out  1  D-cache transaction done, 1-cycle pulse.
- pmem_read  out  1  read to cacheline adaptor.
- pmem_write  out  1  write to cacheline adaptor.
- pmem_address  out  ADDR_W  forwarded address.
- pmem_wdata  out  LINE_W  forwarded write data.
- pmem_rdata  in  LINE_W  line from adaptor.
- pmem_resp  in  1  adaptor done, 1-cycle pulse.

Behaviour:

Registers and reset:
- Registers: state ∈ {IDLE, SERVE_I, SERVE_D}; last_grant ∈ {INST, DATA}.
- On rst==0 at a clock edge: state=IDLE, last_grant=INST (data wins the first tie).
- Reset overrides everything, including an in-flight transaction. The adaptor is reset by the same rst.

Outputs by state (all Moore except resp and rdata forwarding):
- IDLE:
  - pmem_read=0, pmem_write=0.
  - pmem_address=0, pmem_wdata=0.
  - Both resp=0.
- SERVE_I:
  - pmem_read=1, pmem_write=0.
  - pmem_address=icache_pmem_address.
  - pmem_wdata=0.
- SERVE_D:
  - pmem_read=dcache_pmem_read & ~dcache_pmem_write.
  - pmem_write=dcache_pmem_write.
  - pmem_address=dcache_pmem_address.
  - pmem_wdata=dcache_pmem_wdata.
  - If the D-cache asserts both read and write, the write wins.
- icache_pmem_rdata and dcache_pmem_rdata both equal pmem_rdata at all times.
- icache_pmem_resp = (state==SERVE_I) & pmem_resp.
- dcache_pmem_resp = (state==SERVE_D) & pmem_resp.
- Both resp outputs are combinational, in the same cycle as pmem_resp.

Arbitration, evaluated in IDLE:
- ireq = icache_pmem_read.
- dreq = dcache_pmem_read | dcache_pmem_write.
- Only ireq → SERVE_I.
- Only dreq → SERVE_D.
- Both → serve the requester opposite last_grant: last_grant==INST → SERVE_D, else SERVE_I.
- Neither → stay IDLE.
- last_grant is updated to the granted requester on the IDLE→SERVE_x transition.

Completion:
- In SERVE_x, when pmem_resp==1 → IDLE next cycle. Otherwise hold.
- There is no timeout; the FSM waits indefinitely.

Latency:
- A request visible in IDLE at cycle n is driven to pmem at cycle n+1.
- pmem_resp at cycle m produces the requester resp at cycle m and state IDLE at m+1.
- A queued request from the other cache is therefore driven to pmem at m+2.
- Minimum turnaround is one IDLE bubble per transaction.

Requester contract:
- A requester holds its request and address/wdata stable from assertion until its resp cycle.
- A requester deasserts its request by the cycle after resp.
- The arbiter does not latch requester inputs.
- A request dropped early is a protocol error; behaviour is undefined and is flagged by a bench assertion.
- pmem_resp outside SERVE_x is ignored and is also a bench assertion.

Test Plan:
- Single I miss: icache_pmem_read=1, addr 0x0000_1000; adaptor resp 5 cycles later with rdata=0xA5..A5.
  - pmem_read=1 and pmem_address=0x1000 from the cycle after request.
  - icache_pmem_resp pulses with rdata 0xA5..A5; dcache_pmem_resp stays 0.
- Simultaneous I read 0x1000 and D read 0x2000 right after reset → D served first (last_grant=INST).
  - D resp at m; I driven at m+2 at 0x1000; I resp follows.
- Back-to-back D write-backs: D write to 0x3000 with I pending, then D requests again immediately.
  - The second grant goes to I (round-robin), then the D request is served.
  - pmem_wdata matches the D data during the write.
- D read+write asserted together → pmem_write=1, pmem_read=0.
- Reset mid-op: assert rst=0 during SERVE_D before pmem_resp.
  - Next cycle: state IDLE, pmem_read=pmem_write=0, no resp pulses.
  - After rst=1 with a tie, D is granted.
- Idle noise: pmem_resp pulse in IDLE → no resp output and state unchanged.

Source files
------------

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one physical-memory cacheline port between I-cache and D-cache.
// One whole line transaction is in flight at a time; an IDLE cycle separates transactions.
module cacheline_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icache_pmem_read,
    input  logic [ADDR_W-1:0] icache_pmem_address,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,

    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [ADDR_W-1:0] dcache_pmem_address,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_t;

    state_t state;
    grant_t last_grant;
    logic   ireq;
    logic   dreq;

    assign ireq = icache_pmem_read;
    assign dreq = dcache_pmem_read | dcache_pmem_write;

    // Grant in IDLE; a tie goes to whichever cache was not granted last.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= GRANT_INST;
        end else begin
            case (state)
                IDLE: begin
                    if (ireq && (!dreq || last_grant == GRANT_DATA)) begin
                        state      <= SERVE_I;
                        last_grant <= GRANT_INST;
                    end else if (dreq) begin
                        state      <= SERVE_D;
                        last_grant <= GRANT_DATA;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port steering follows the state; resp is passed through in the same cycle.
    always_comb begin
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = '0;
        pmem_wdata       = '0;
        icache_pmem_resp = 1'b0;
        dcache_pmem_resp = 1'b0;
        case (state)
            SERVE_I: begin
                pmem_read        = 1'b1;
                pmem_address     = icache_pmem_address;
                icache_pmem_resp = pmem_resp;
            end
            SERVE_D: begin
                pmem_read        = dcache_pmem_read & ~dcache_pmem_write;
                pmem_write       = dcache_pmem_write;
                pmem_address     = dcache_pmem_address;
                pmem_wdata       = dcache_pmem_wdata;
                dcache_pmem_resp = pmem_resp;
            end
            default: ;
        endcase
    end

    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level ownership model.
module tb_cacheline_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              icache_pmem_read;
    logic [ADDR_W-1:0] icache_pmem_address;
    logic [LINE_W-1:0] icache_pmem_rdata;
    logic              icache_pmem_resp;
    logic              dcache_pmem_read;
    logic              dcache_pmem_write;
    logic [ADDR_W-1:0] dcache_pmem_address;
    logic [LINE_W-1:0] dcache_pmem_wdata;
    logic [LINE_W-1:0] dcache_pmem_rdata;
    logic              dcache_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    always #5 clk = ~clk;

    cacheline_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_address (icache_pmem_address),
        .icache_pmem_rdata   (icache_pmem_rdata),
        .icache_pmem_resp    (icache_pmem_resp),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .dcache_pmem_rdata   (dcache_pmem_rdata),
        .dcache_pmem_resp    (dcache_pmem_resp),
        .pmem_read           (pmem_read),
        .pmem_write          (pmem_write),
        .pmem_address        (pmem_address),
        .pmem_wdata          (pmem_wdata),
        .pmem_rdata          (pmem_rdata),
        .pmem_resp           (pmem_resp)
    );

    int checks = 0;
    int errors = 0;

    // Model: who currently owns the port (0 none, 1 I-cache, 2 D-cache) and who wins the next tie.
    int owner        = 0;
    bit prefer_data  = 1'b1;
    int drop_events  = 0;
    int noise_events = 0;
    bit exp_iresp;
    bit exp_dresp;

    localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_WB = {8{32'hDEAD_BEEF}};

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        icache_pmem_read    = 1'b0;
        icache_pmem_address = '0;
        dcache_pmem_read    = 1'b0;
        dcache_pmem_write   = 1'b0;
        dcache_pmem_address = '0;
        dcache_pmem_wdata   = '0;
        pmem_rdata          = '0;
        pmem_resp           = 1'b0;
    endtask

    // Inputs are set just after a falling edge; check outputs, advance the model, then move one cycle.
    task automatic tick();
        logic              er;
        logic              ew;
        logic [ADDR_W-1:0] ea;
        logic [LINE_W-1:0] ewd;
        bit                ireq;
        bit                dreq;
        #1;
        er = 1'b0; ew = 1'b0; ea = '0; ewd = '0;
        exp_iresp = 1'b0; exp_dresp = 1'b0;
        if (owner == 1) begin
            er = 1'b1;
            ea = icache_pmem_address;
            exp_iresp = pmem_resp;
        end else if (owner == 2) begin
            ew  = dcache_pmem_write;
            er  = dcache_pmem_read && !dcache_pmem_write;
            ea  = dcache_pmem_address;
            ewd = dcache_pmem_wdata;
            exp_dresp = pmem_resp;
        end
        chk("pmem_read",    LINE_W'(pmem_read),        LINE_W'(er));
        chk("pmem_write",   LINE_W'(pmem_write),       LINE_W'(ew));
        chk("pmem_address", LINE_W'(pmem_address),     LINE_W'(ea));
        chk("pmem_wdata",   pmem_wdata,                ewd);
        chk("icache_resp",  LINE_W'(icache_pmem_resp), LINE_W'(exp_iresp));
        chk("dcache_resp",  LINE_W'(dcache_pmem_resp), LINE_W'(exp_dresp));
        chk("icache_rdata", icache_pmem_rdata,         pmem_rdata);
        chk("dcache_rdata", dcache_pmem_rdata,         pmem_rdata);

        ireq = icache_pmem_read;
        dreq = dcache_pmem_read || dcache_pmem_write;
        if (!rst) begin
            owner       = 0;
            prefer_data = 1'b1;
        end else if (owner == 0) begin
            if (pmem_resp) noise_events++;
            if (ireq && dreq) begin
                owner       = prefer_data ? 2 : 1;
                prefer_data = !prefer_data;
            end else if (ireq) begin
                owner       = 1;
                prefer_data = 1'b1;
            end else if (dreq) begin
                owner       = 2;
                prefer_data = 1'b0;
            end
        end else begin
            if (owner == 1 && !ireq) drop_events++;
            if (owner == 2 && !dreq) drop_events++;
            if (pmem_resp) owner = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        rst = 1'b1;
    endtask

    bit i_pend = 1'b0, i_off = 1'b0, d_pend = 1'b0, d_off = 1'b0;
    int kind;

    initial begin
        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        owner = 0;
        prefer_data = 1'b1;

        // Reset state
        #1;
        chk("reset_read",  LINE_W'(pmem_read),    '0);
        chk("reset_write", LINE_W'(pmem_write),   '0);
        chk("reset_addr",  LINE_W'(pmem_address), '0);
        tick();
        rst = 1'b1;
        tick();

        // Single I miss, adaptor answers on the fifth serving cycle
        icache_pmem_read    = 1'b1;
        icache_pmem_address = 32'h0000_1000;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("imiss_read", LINE_W'(pmem_read),    LINE_W'(1'b1));
            chk("imiss_addr", LINE_W'(pmem_address), LINE_W'(32'h1000));
            tick();
        end
        pmem_resp  = 1'b1;
        pmem_rdata = PAT_A5;
        #1;
        chk("imiss_iresp", LINE_W'(icache_pmem_resp), LINE_W'(1'b1));
        chk("imiss_dresp", LINE_W'(dcache_pmem_resp), LINE_W'(1'b0));
        chk("imiss_rdata", icache_pmem_rdata,         PAT_A5);
        tick();
        idle_inputs();
        tick();

        // Simultaneous misses right after reset: D first, I at m+2
        do_reset();
        icache_pmem_read    = 1'b1;
        icache_pmem_address = 32'h0000_1000;
        dcache_pmem_read    = 1'b1;
        dcache_pmem_address = 32'h0000_2000;
        tick();
        #1;
        chk("tie_first_addr", LINE_W'(pmem_address), LINE_W'(32'h2000));
        tick();
        pmem_resp = 1'b1;
        #1;
        chk("tie_dresp", LINE_W'(dcache_pmem_resp), LINE_W'(1'b1));
        chk("tie_iresp", LINE_W'(icache_pmem_resp), LINE_W'(1'b0));
        tick();
        pmem_resp        = 1'b0;
        dcache_pmem_read = 1'b0;
        #1;
        chk("tie_bubble", LINE_W'(pmem_read), LINE_W'(1'b0));
        tick();
        #1;
        chk("tie_second_addr", LINE_W'(pmem_address), LINE_W'(32'h1000));
        tick();
        pmem_resp = 1'b1;
        tick();
        idle_inputs();
        tick();

        // D write-back with I pending; D re-requests at once and I still wins the next tie
        dcache_pmem_write   = 1'b1;
        dcache_pmem_address = 32'h0000_3000;
        dcache_pmem_wdata   = PAT_WB;
        icache_pmem_read    = 1'b1;
        icache_pmem_address = 32'h0000_1040;
        tick();
        #1;
        chk("wb_write", LINE_W'(pmem_write), LINE_W'(1'b1));
        chk("wb_wdata", pmem_wdata,          PAT_WB);
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp           = 1'b0;
        dcache_pmem_write   = 1'b0;
        dcache_pmem_read    = 1'b1;
        dcache_pmem_address = 32'h0000_3040;
        tick();
        #1;
        chk("rr_grant_i", LINE_W'(pmem_address), LINE_W'(32'h1040));
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp        = 1'b0;
        icache_pmem_read = 1'b0;
        tick();
        #1;
        chk("rr_then_d", LINE_W'(pmem_address), LINE_W'(32'h3040));
        pmem_resp = 1'b1;
        tick();
        idle_inputs();
        tick();

        // Read and write together: write wins
        dcache_pmem_read    = 1'b1;
        dcache_pmem_write   = 1'b1;
        dcache_pmem_address = 32'h0000_4000;
        tick();
        #1;
        chk("rw_write", LINE_W'(pmem_write), LINE_W'(1'b1));
        chk("rw_read",  LINE_W'(pmem_read),  LINE_W'(1'b0));
        pmem_resp = 1'b1;
        tick();
        idle_inputs();
        tick();

        // Reset while a D read is in flight, then a tie goes to D
        dcache_pmem_read    = 1'b1;
        dcache_pmem_address = 32'h0000_5000;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        icache_pmem_read    = 1'b1;
        icache_pmem_address = 32'h0000_6000;
        #1;
        chk("rst_mid_read",  LINE_W'(pmem_read),        LINE_W'(1'b0));
        chk("rst_mid_write", LINE_W'(pmem_write),       LINE_W'(1'b0));
        chk("rst_mid_dresp", LINE_W'(dcache_pmem_resp), LINE_W'(1'b0));
        tick();
        #1;
        chk("rst_tie_d", LINE_W'(pmem_address), LINE_W'(32'h5000));
        pmem_resp = 1'b1;
        tick();
        pmem_resp        = 1'b0;
        dcache_pmem_read = 1'b0;
        tick();
        pmem_resp = 1'b1;
        tick();
        idle_inputs();
        tick();

        // Stray adaptor response while idle
        pmem_resp  = 1'b1;
        pmem_rdata = PAT_WB;
        #1;
        chk("noise_iresp", LINE_W'(icache_pmem_resp), LINE_W'(1'b0));
        chk("noise_dresp", LINE_W'(dcache_pmem_resp), LINE_W'(1'b0));
        tick();
        idle_inputs();
        #1;
        chk("noise_idle",  LINE_W'(pmem_read), LINE_W'(1'b0));
        chk("noise_count", LINE_W'(noise_events), LINE_W'(1));
        tick();

        // Random traffic honouring the requester contract
        for (int n = 0; n < 3000; n++) begin
            if (i_off) begin
                icache_pmem_read = 1'b0;
                i_off = 1'b0;
            end else if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1;
                icache_pmem_read    = 1'b1;
                icache_pmem_address = $urandom() & 32'hFFFF_FFE0;
            end
            if (d_off) begin
                dcache_pmem_read  = 1'b0;
                dcache_pmem_write = 1'b0;
                d_off = 1'b0;
            end else if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1;
                kind   = int'($urandom_range(0, 2));
                dcache_pmem_read    = (kind != 1);
                dcache_pmem_write   = (kind != 0);
                dcache_pmem_address = $urandom() & 32'hFFFF_FFE0;
                dcache_pmem_wdata   = {8{$urandom()}};
            end
            pmem_resp  = (owner != 0) && ($urandom_range(0, 3) == 0);
            pmem_rdata = {8{$urandom()}};
            tick();
            if (exp_iresp) begin i_pend = 1'b0; i_off = 1'b1; end
            if (exp_dresp) begin d_pend = 1'b0; d_off = 1'b1; end
        end

        chk("protocol_drops", LINE_W'(drop_events),  '0);
        chk("protocol_noise", LINE_W'(noise_events), LINE_W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
